// File: rtl/rr_requester_pkg.sv
// rtl/rr_requester_pkg.sv - shared constants and grant-vector helper for rr_requester
package rr_requester_pkg;

  localparam int DEFAULT_CLIENTS = 32;
  localparam int AGE_W           = 16;
  localparam int STARVE_LIMIT    = 2 * DEFAULT_CLIENTS;
  localparam int VEC_W           = 64;

  // True when more than one bit is set: clearing the lowest set bit leaves something behind.
  function automatic logic popcount_gt1(input logic [VEC_W-1:0] vec);
    return |(vec & (vec - VEC_W'(1)));
  endfunction

endpackage

// File: rtl/rr_req_slot.sv
// rtl/rr_req_slot.sv - one client's pending counter, sticky overflow and (RR_REQUESTER_AGE_EN) age counter
module rr_req_slot
  import rr_requester_pkg::*;
#(
  parameter int DEPTH = 7,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic clock,
  input  logic reset,
  input  logic push,
  input  logic grant,
  output logic request,
`ifdef RR_REQUESTER_AGE_EN
  output logic starving,
`endif
  output logic overflow
);

  logic [CNT_W-1:0] pending;
  logic             full;
  logic             empty;
  logic             inc;
  logic             dec;

  assign full    = (pending == CNT_W'(DEPTH));
  assign empty   = (pending == '0);
  assign dec     = grant && !empty;
  // A grant frees a slot in the same cycle, so a push at full is still taken when granted.
  assign inc     = push && (!full || dec);
  assign request = !empty;

  always_ff @(posedge clock) begin
    if (reset) begin
      pending  <= '0;
      overflow <= 1'b0;
    end else begin
      if (inc && !dec) begin
        pending <= pending + CNT_W'(1);
      end else if (dec && !inc) begin
        pending <= pending - CNT_W'(1);
      end
      if (push && !inc) begin
        overflow <= 1'b1;
      end
    end
  end

`ifdef RR_REQUESTER_AGE_EN
  logic [AGE_W-1:0] age;
  logic [AGE_W-1:0] age_next;

  always_comb begin
    age_next = age;
    if (!request || grant) begin
      age_next = '0;
    end else if (!(&age)) begin
      age_next = age + AGE_W'(1);
    end
  end

  // Flag is computed from the next age so a grant drops it on the very next cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      age      <= '0;
      starving <= 1'b0;
    end else begin
      age      <= age_next;
      starving <= (age_next >= AGE_W'(STARVE_LIMIT));
    end
  end
`endif

endmodule

// File: rtl/rr_requester.sv
// rtl/rr_requester.sv - client-side request front end for rr_arbiter with grant checking
// Optional age/starve tracking is enabled by defining RR_REQUESTER_AGE_EN.
module rr_requester
  import rr_requester_pkg::*;
#(
  parameter  int CLIENTS = 32,
  parameter  int DEPTH   = 7,
  localparam int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [CLIENTS-1:0] push,
  input  logic [CLIENTS-1:0] grant,
  output logic [CLIENTS-1:0] request,
  output logic [CLIENTS-1:0] overflow,
`ifdef RR_REQUESTER_AGE_EN
  output logic               starve,
`endif
  output logic               grant_err,
  output logic               idle
);

`ifdef RR_REQUESTER_AGE_EN
  logic [CLIENTS-1:0] starving;
  assign starve = |starving;
`endif

  for (genvar i = 0; i < CLIENTS; i++) begin : g_slot
    rr_req_slot #(
      .DEPTH (DEPTH),
      .CNT_W (CNT_W)
    ) u_slot (
      .clock    (clock),
      .reset    (reset),
      .push     (push[i]),
      .grant    (grant[i]),
      .request  (request[i]),
`ifdef RR_REQUESTER_AGE_EN
      .starving (starving[i]),
`endif
      .overflow (overflow[i])
    );
  end

  // request is the registered non-empty state, so this flags grants to clients that were not asking.
  always_ff @(posedge clock) begin
    if (reset) begin
      grant_err <= 1'b0;
    end else begin
      grant_err <= popcount_gt1(VEC_W'(grant)) || (|(grant & ~request));
    end
  end

  assign idle = ~|request;

endmodule
